// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Writer side of the program memory write port. Parses a byte stream framed as
//   SYNC_BYTE, count[7:0], count[15:8], 4*count data bytes (LSB first)
// into 32-bit words and issues one-cycle write strobes. The core is held in
// reset (cpu_hold) until the whole image has been written.
//
// Optional feature (macro LOADER_CHECKSUM_EN): a trailing byte equal to the XOR
// of all data bytes is expected after the data. A mismatch raises load_error
// and keeps cpu_hold asserted in DONE.
//
// Ports
//   clk               clock, posedge
//   reset_n           asynchronous active-low reset
//   restart           pulse, re-arms the loader from any state
//   rx_byte[7:0]      received byte
//   rx_valid          rx_byte valid this cycle (always accepted)
//   mem_write_enable  one-cycle write strobe
//   mem_byte_address  BASE_ADDR + 4*word_index
//   mem_write_data    assembled word
//   cpu_hold          1 = keep core in reset
//   load_done         image written (level until restart/reset)
//   load_error        sticky: word count > MEM_WORDS or checksum failure
// -----------------------------------------------------------------------------
module program_loader #(
  parameter int unsigned MEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        restart,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        mem_write_enable,
  output logic [31:0] mem_byte_address,
  output logic [31:0] mem_write_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned BW = 8;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_WAIT_SYNC = 3'd0,
    S_LEN_LO    = 3'd1,
    S_LEN_HI    = 3'd2,
    S_DATA      = 3'd3,
    S_CHECK     = 3'd4,
    S_DONE      = 3'd5
  } state_e;
  // State entered once the data section is exhausted
  localparam state_e S_TAIL = S_CHECK;
`else
  typedef enum logic [2:0] {
    S_WAIT_SYNC = 3'd0,
    S_LEN_LO    = 3'd1,
    S_LEN_HI    = 3'd2,
    S_DATA      = 3'd3,
    S_DONE      = 3'd4
  } state_e;
  localparam state_e S_TAIL = S_DONE;
`endif

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   word_idx_q, word_idx_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [23:0]     asm_q, asm_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   wdata_q, wdata_d;
  logic            hold_q, hold_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [BW-1:0]   csum_q, csum_d;
  logic            csum_ok_q, csum_ok_d;
`endif

  // Helper terms for the current byte
  logic [CW-1:0]   len_c;
  logic [AW-1:0]   word_c;
  logic [AW-1:0]   word_addr_c;
  logic            last_word_c;
  logic            in_range_c;

  assign len_c       = {rx_byte, count_q[BW-1:0]};
  assign word_c      = {rx_byte, asm_q};
  assign word_addr_c = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
  assign last_word_c = (word_idx_q + 16'd1) == count_q;
  assign in_range_c  = AW'(word_idx_q) < MEM_WORDS;

  // State and datapath register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_WAIT_SYNC;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
      csum_ok_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
      csum_ok_q  <= csum_ok_d;
`endif
    end
  end

  // Next-state, frame parsing and output computation
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    hold_d     = 1'b1;
    done_d     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    csum_ok_d  = csum_ok_q;
`endif

    if (restart) begin
      // Re-arm; any partially assembled word is dropped
      state_d    = S_WAIT_SYNC;
      count_d    = '0;
      word_idx_d = '0;
      byte_cnt_d = '0;
      asm_d      = '0;
      err_d      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_d     = '0;
      csum_ok_d  = 1'b0;
`endif
    end else if (rx_valid) begin
      unique case (state_q)
        S_WAIT_SYNC: begin
          if (rx_byte == SYNC_BYTE) begin
            state_d    = S_LEN_LO;
            word_idx_d = '0;
            byte_cnt_d = '0;
            asm_d      = '0;
`ifdef LOADER_CHECKSUM_EN
            csum_d     = '0;
`endif
          end
        end
        S_LEN_LO: begin
          count_d = {8'h00, rx_byte};
          state_d = S_LEN_HI;
        end
        S_LEN_HI: begin
          count_d = len_c;
          // Oversized images still get consumed; only the write is suppressed
          if (AW'(len_c) > MEM_WORDS) begin
            err_d = 1'b1;
          end
          state_d = (len_c == '0) ? S_TAIL : S_DATA;
        end
        S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_byte;
`endif
          byte_cnt_d = byte_cnt_q + 2'd1;
          unique case (byte_cnt_q)
            2'd0: asm_d[7:0]   = rx_byte;
            2'd1: asm_d[15:8]  = rx_byte;
            2'd2: asm_d[23:16] = rx_byte;
            2'd3: begin
              // Word complete: strobe on the following cycle
              asm_d      = '0;
              word_idx_d = word_idx_q + 16'd1;
              if (in_range_c) begin
                we_d    = 1'b1;
                addr_d  = word_addr_c;
                wdata_d = word_c;
              end
              if (last_word_c) begin
                state_d = S_TAIL;
              end
            end
            default: asm_d = asm_q;
          endcase
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          csum_ok_d = (rx_byte == csum_q);
          if (rx_byte != csum_q) begin
            err_d = 1'b1;
          end
          state_d = S_DONE;
        end
`endif
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_WAIT_SYNC;
        end
      endcase
    end

    // Status flags lag the DONE state by one cycle so the final strobe
    // completes before the core is released
    if (!restart) begin
      done_d = (state_q == S_DONE);
`ifdef LOADER_CHECKSUM_EN
      hold_d = !((state_q == S_DONE) && csum_ok_q);
`else
      hold_d = (state_q != S_DONE);
`endif
    end
  end

  assign mem_write_enable = we_q;
  assign mem_byte_address = addr_q;
  assign mem_write_data   = wdata_q;
  assign cpu_hold         = hold_q;
  assign load_done        = done_q;
  assign load_error       = err_q;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
// Self-checking bench for program_loader. A frame-level model turns the byte
// schedule of each frame into expected write strobes (cycle, address, data) and
// the cycles from which load_done / cpu_hold release / load_error apply; a
// compare process checks the DUT against it on every falling edge. Directed
// literal checks pin the model for the documented example frames.
// -----------------------------------------------------------------------------
module tb_program_loader;

  localparam int unsigned MEM_WORDS = 256;
  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam logic [7:0]  SYNC      = 8'hA5;
  localparam int          NEVER     = 32'h7fff_ffff;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        restart;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        mem_write_enable;
  logic [31:0] mem_byte_address;
  logic [31:0] mem_write_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  program_loader dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .restart          (restart),
    .rx_byte          (rx_byte),
    .rx_valid         (rx_valid),
    .mem_write_enable (mem_write_enable),
    .mem_byte_address (mem_byte_address),
    .mem_write_data   (mem_write_data),
    .cpu_hold         (cpu_hold),
    .load_done        (load_done),
    .load_error       (load_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        obs_q[$];
  logic [7:0] tx_bytes[$];
  int         tx_gap[$];
  int         tx_cyc[$];
  int         exp_done_cyc = NEVER;
  int         exp_rel_cyc  = NEVER;
  int         exp_err_cyc  = NEVER;
  int         n_checks = 0;
  int         n_pass   = 0;
  bit         chk_en   = 1'b0;
  bit         exp_we;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, got, want, cyc);
  endtask

  // Frame-level model: locate the frame in the scheduled bytes, derive words
  // and the cycles at which each observable effect must appear.
  function automatic void model();
    int          s;
    int          n;
    int          b0;
    int          last;
    logic [31:0] w;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  x;
    x = 8'h00;
`endif
    s = -1;
    foreach (tx_bytes[j]) if (s < 0 && tx_bytes[j] == SYNC) s = j;
    if (s < 0 || s + 2 >= tx_bytes.size()) return;
    n = int'({tx_bytes[s+2], tx_bytes[s+1]});
    if (n > int'(MEM_WORDS)) exp_err_cyc = tx_cyc[s+2] + 1;
    for (int i = 0; i < n; i++) begin
      b0 = s + 3 + 4 * i;
      if (b0 + 3 >= tx_bytes.size()) return;
      w = {tx_bytes[b0+3], tx_bytes[b0+2], tx_bytes[b0+1], tx_bytes[b0]};
`ifdef LOADER_CHECKSUM_EN
      x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
`endif
      if (i < int'(MEM_WORDS))
        exp_q.push_back('{tx_cyc[b0+3] + 1, BASE + 32'(4 * i), w});
    end
    last = s + 2 + 4 * n;
`ifdef LOADER_CHECKSUM_EN
    if (last + 1 >= tx_bytes.size()) return;
    last++;
    if (tx_bytes[last] != x && exp_err_cyc == NEVER) exp_err_cyc = tx_cyc[last] + 1;
    exp_done_cyc = tx_cyc[last] + 2;
    exp_rel_cyc  = (tx_bytes[last] == x) ? exp_done_cyc : NEVER;
`else
    exp_done_cyc = tx_cyc[last] + 2;
    exp_rel_cyc  = exp_done_cyc;
`endif
  endfunction

`ifdef LOADER_CHECKSUM_EN
  // Insert the correct XOR byte right after the data section
  function automatic void add_csum();
    int         s;
    int         n;
    logic [7:0] x;
    s = -1;
    x = 8'h00;
    foreach (tx_bytes[j]) if (s < 0 && tx_bytes[j] == SYNC) s = j;
    n = int'({tx_bytes[s+2], tx_bytes[s+1]});
    for (int j = 0; j < 4 * n; j++) x = x ^ tx_bytes[s+3+j];
    tx_bytes.insert(s + 3 + 4 * n, x);
  endfunction
`endif

  task automatic set_gaps(input int g);
    tx_gap.delete();
    foreach (tx_bytes[j]) tx_gap.push_back(g);
  endtask

  task automatic clear_model();
    exp_q.delete();
    obs_q.delete();
    exp_done_cyc = NEVER;
    exp_rel_cyc  = NEVER;
    exp_err_cyc  = NEVER;
  endtask

  // Schedule the bytes, run the model, then drive them on their cycles
  task automatic send_frame();
    int t;
    @(posedge clk); #1;
    t = cyc;
    tx_cyc.delete();
    foreach (tx_bytes[j]) begin
      t += tx_gap[j];
      tx_cyc.push_back(t);
      t++;
    end
    model();
    foreach (tx_bytes[j]) begin
      while (cyc < tx_cyc[j]) begin
        rx_valid = 1'b0;
        @(posedge clk); #1;
      end
      rx_valid = 1'b1;
      rx_byte  = tx_bytes[j];
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    restart  = 1'b0;
    clear_model();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      exp_we = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      check("strobe", 32'(mem_write_enable), 32'(exp_we));
      if (exp_we) begin
        check("address", mem_byte_address, exp_q[0].addr);
        check("data", mem_write_data, exp_q[0].data);
        void'(exp_q.pop_front());
      end
      if (mem_write_enable) obs_q.push_back('{cyc, mem_byte_address, mem_write_data});
      check("load_done", 32'(load_done), 32'(cyc >= exp_done_cyc));
      check("cpu_hold", 32'(cpu_hold), 32'(cyc < exp_rel_cyc));
      check("load_error", 32'(load_error), 32'(cyc >= exp_err_cyc));
    end
  end

  initial begin
    reset_n  = 1'b1;
    restart  = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    #1 reset_n = 1'b0;
    #2;
    check("rst_we", 32'(mem_write_enable), 32'd0);
    check("rst_addr", mem_byte_address, 32'h0);
    check("rst_data", mem_write_data, 32'h0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_error), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Example frame with a leading junk byte, one idle cycle between bytes
    tx_bytes = '{8'h00, 8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    add_csum();
`endif
    set_gaps(1);
    send_frame();
    settle(4);
    check("t1_nwrites", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() >= 2) begin
      check("t1_addr0", obs_q[0].addr, 32'h0);
      check("t1_data0", obs_q[0].data, 32'h0000_0013);
      check("t1_addr1", obs_q[1].addr, 32'h4);
      check("t1_data1", obs_q[1].data, 32'h0010_0093);
    end
    check("t1_done", 32'(load_done), 32'd1);
    check("t1_hold", 32'(cpu_hold), 32'd0);
    check("t1_pending", 32'(exp_q.size()), 32'd0);

    // Same frame back to back
    do_reset();
    tx_bytes.delete(0);
    set_gaps(0);
    send_frame();
    settle(4);
    check("t2_nwrites", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() >= 2)
      check("t2_spacing", 32'(obs_q[1].cyc - obs_q[0].cyc), 32'd4);
    check("t2_pending", 32'(exp_q.size()), 32'd0);

    // Empty image; trailing bytes after DONE must be ignored
    do_reset();
    tx_bytes = '{8'hA5, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    add_csum();
`endif
    tx_bytes.push_back(8'hA5); tx_bytes.push_back(8'h01); tx_bytes.push_back(8'h00);
    tx_bytes.push_back(8'h11); tx_bytes.push_back(8'h22);
    tx_bytes.push_back(8'h33); tx_bytes.push_back(8'h44);
    set_gaps(0);
    send_frame();
    settle(4);
    check("t3_nwrites", 32'(obs_q.size()), 32'd0);
    check("t3_done", 32'(load_done), 32'd1);
    check("t3_hold", 32'(cpu_hold), 32'd0);

    // 257 words into a 256-word memory
    do_reset();
    tx_bytes = '{8'hA5, 8'h01, 8'h01};
    for (int j = 0; j < 257 * 4; j++) tx_bytes.push_back(8'(j) ^ 8'h5A);
`ifdef LOADER_CHECKSUM_EN
    add_csum();
`endif
    set_gaps(0);
    send_frame();
    settle(4);
    check("t4_nwrites", 32'(obs_q.size()), 32'd256);
    if (obs_q.size() >= 256) begin
      check("t4_last_addr", obs_q[255].addr, 32'h0000_03FC);
      check("t4_last_data", obs_q[255].data, 32'hA5A4_A7A6);
    end
    check("t4_err", 32'(load_error), 32'd1);
    check("t4_done", 32'(load_done), 32'd1);
    check("t4_hold", 32'(cpu_hold), 32'd0);
    check("t4_pending", 32'(exp_q.size()), 32'd0);

    // restart from DONE clears the sticky flags
    chk_en  = 1'b0;
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    settle(1);
    check("rs_err", 32'(load_error), 32'd0);
    check("rs_done", 32'(load_done), 32'd0);
    check("rs_hold", 32'(cpu_hold), 32'd1);
    clear_model();
    chk_en = 1'b1;

    // restart mid-word, with a byte presented on the restart cycle
    do_reset();
    tx_bytes = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
    set_gaps(0);
    send_frame();
    restart  = 1'b1;
    rx_valid = 1'b1;
    rx_byte  = 8'h33;
    @(posedge clk); #1;
    restart  = 1'b0;
    rx_valid = 1'b0;
    tx_bytes = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef LOADER_CHECKSUM_EN
    add_csum();
`endif
    set_gaps(0);
    send_frame();
    settle(4);
    check("t5_nwrites", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() >= 1) begin
      check("t5_addr0", obs_q[0].addr, 32'h0);
      check("t5_data0", obs_q[0].data, 32'hEFBE_ADDE);
    end
    check("t5_done", 32'(load_done), 32'd1);

    // reset_n asserted on the cycle the 4th byte arrives
    do_reset();
    tx_bytes = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
    set_gaps(0);
    send_frame();
    rx_valid = 1'b1;
    rx_byte  = 8'h44;
    reset_n  = 1'b0;
    clear_model();
    #1;
    check("t6_rst_we", 32'(mem_write_enable), 32'd0);
    check("t6_rst_hold", 32'(cpu_hold), 32'd1);
    @(posedge clk); #1;
    check("t6_rst_we_edge", 32'(mem_write_enable), 32'd0);
    rx_valid = 1'b0;
    reset_n  = 1'b1;
    tx_bytes = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef LOADER_CHECKSUM_EN
    add_csum();
`endif
    set_gaps(2);
    send_frame();
    settle(4);
    check("t6_nwrites", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() >= 1) check("t6_data0", obs_q[0].data, 32'h1234_5678);
    check("t6_done", 32'(load_done), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // Correct checksum for 0x11223344 is 0x44; 0x45 must be rejected
    do_reset();
    tx_bytes = '{8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h45};
    set_gaps(0);
    send_frame();
    settle(4);
    check("ck_done", 32'(load_done), 32'd1);
    check("ck_hold", 32'(cpu_hold), 32'd1);
    check("ck_err", 32'(load_error), 32'd1);
`endif

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
